control_sequencer: RTL

- Hardwired Moore control unit that sequences the 32-bit bus datapath (R0–R15, Y, Z, HI/LO, PC, MAR/MDR, IR, ALU) through fetch and execute micro-steps.
- Decodes IR and drives every bus-source enable, register-load enable, register-select, ALU opcode and memory strobe.
- Sits beside the datapath; memory supplies `mem_ready` to stretch Read/Write steps.

---
 rtl/control_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired Moore control unit for the 32-bit single-bus datapath
// (R0-R15, Y, Z, HI/LO, PC, MAR/MDR, IR, ALU).  A state register steps through
// the fetch micro-steps T0-T2, then the execute micro-steps T3-T7 selected by
// the IR opcode.  Every datapath control line is decoded combinationally from
// the current state and the IR contents.
//
// Ports
//   clock      in   system clock, all state updates on the rising edge
//   clear      in   synchronous active-low reset
//   ir[31:0]   in   IR contents, opcode = ir[31:27]
//   mem_ready  in   memory finishes the pending Read/Write this cycle
//   bus_src    out  one-hot bus driver
//                   {BAout,Cout,Rout,LOout,HIout,MDRout,Zlowout,Zhighout,PCout}
//   bus_dst    out  load enables
//                   {Rin,LOin,HIin,Yin,IRin,MDRin,PCin,Zin,MARin}
//   gr_sel     out  {Gra,Grb,Grc} register-field select
//   IncPC      out  ALU computes bus+1
//   alu_op     out  ALU operation code
//   Read       out  memory read strobe (MDR loads Mdatain)
//   Write      out  memory write strobe
//   run        out  high while executing, low in RESET/HALT
//   illegal    out  one-cycle pulse in T3 for an unsupported opcode
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int                OPW     = 5,
    parameter logic [OPW-1:0]    ADD_OPC = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [8:0]  bus_src,
    output logic [8:0]  bus_dst,
    output logic [2:0]  gr_sel,
    output logic        IncPC,
    output logic [4:0]  alu_op,
    output logic        Read,
    output logic        Write,
    output logic        run,
    output logic        illegal
);

    // Opcode map
    localparam logic [OPW-1:0] OPC_LD   = 5'b00000;
    localparam logic [OPW-1:0] OPC_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OPC_ST   = 5'b00010;
    localparam logic [OPW-1:0] OPC_ALU0 = 5'b00011;  // add .. or
    localparam logic [OPW-1:0] OPC_ALU1 = 5'b01011;
    localparam logic [OPW-1:0] OPC_IMM0 = 5'b01100;  // addi, andi, ori
    localparam logic [OPW-1:0] OPC_IMM1 = 5'b01110;
    localparam logic [OPW-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OPC_MFHI = 5'b11000;
    localparam logic [OPW-1:0] OPC_MFLO = 5'b11001;
    localparam logic [OPW-1:0] OPC_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OPC_HALT = 5'b11011;

    // bus_src bit positions
    localparam int SRC_PC  = 0;
    localparam int SRC_ZHI = 1;
    localparam int SRC_ZLO = 2;
    localparam int SRC_MDR = 3;
    localparam int SRC_HI  = 4;
    localparam int SRC_LO  = 5;
    localparam int SRC_R   = 6;
    localparam int SRC_C   = 7;
    localparam int SRC_BA  = 8;

    // bus_dst bit positions
    localparam int DST_MAR = 0;
    localparam int DST_Z   = 1;
    localparam int DST_PC  = 2;
    localparam int DST_MDR = 3;
    localparam int DST_IR  = 4;
    localparam int DST_Y   = 5;
    localparam int DST_HI  = 6;
    localparam int DST_LO  = 7;
    localparam int DST_R   = 8;

    // gr_sel bit positions
    localparam int GR_C = 0;
    localparam int GR_B = 1;
    localparam int GR_A = 2;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OPW-1:0] opc;

    // Only the opcode field steers sequencing; register and constant fields
    // are consumed by the datapath select/encode logic.
    logic unused_ir;
    assign unused_ir = ^ir[31-OPW:0];

    assign opc = ir[31 -: OPW];

    // -------------------------------------------------------------------------
    // Instruction class decode
    // -------------------------------------------------------------------------
    logic is_alu, is_imm, is_muldiv, is_negnot, is_ldi, is_ld, is_st;
    logic is_mfhi, is_mflo, is_nop, is_halt, is_bad;

    always_comb begin
        is_alu    = (opc >= OPC_ALU0) && (opc <= OPC_ALU1);
        is_imm    = (opc >= OPC_IMM0) && (opc <= OPC_IMM1);
        is_muldiv = (opc == OPC_MUL) || (opc == OPC_DIV);
        is_negnot = (opc == OPC_NEG) || (opc == OPC_NOT);
        is_ldi    = (opc == OPC_LDI);
        is_ld     = (opc == OPC_LD);
        is_st     = (opc == OPC_ST);
        is_mfhi   = (opc == OPC_MFHI);
        is_mflo   = (opc == OPC_MFLO);
        is_nop    = (opc == OPC_NOP);
        is_halt   = (opc == OPC_HALT);
        is_bad    = !(is_alu || is_imm || is_muldiv || is_negnot || is_ldi ||
                      is_ld || is_st || is_mfhi || is_mflo || is_nop || is_halt);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = mem_ready ? S_T2 : S_T1;
            S_T2: begin
                if (is_nop)       state_d = S_T0;
                else if (is_halt) state_d = S_HALT;
                else              state_d = S_T3;
            end
            S_T3: begin
                // Single-step instructions and skipped opcodes finish here.
                if (is_mfhi || is_mflo || is_bad) state_d = S_T0;
                else                              state_d = S_T4;
            end
            S_T4:    state_d = is_negnot ? S_T0 : S_T5;
            S_T5: begin
                if (is_muldiv || is_ld || is_st) state_d = S_T6;
                else                             state_d = S_T0;
            end
            S_T6: begin
                if (is_ld)      state_d = mem_ready ? S_T7 : S_T6;
                else if (is_st) state_d = S_T7;
                else            state_d = S_T0;
            end
            S_T7: begin
                if (is_st) state_d = mem_ready ? S_T0 : S_T7;
                else       state_d = S_T0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore: state plus IR contents)
    // -------------------------------------------------------------------------
    always_comb begin
        bus_src = '0;
        bus_dst = '0;
        gr_sel  = '0;
        IncPC   = 1'b0;
        alu_op  = opc;
        Read    = 1'b0;
        Write   = 1'b0;
        run     = 1'b1;
        illegal = 1'b0;

        unique case (state_q)
            S_RESET, S_HALT: begin
                alu_op = '0;
                run    = 1'b0;
            end
            S_T0: begin
                bus_src[SRC_PC]  = 1'b1;
                bus_dst[DST_MAR] = 1'b1;
                bus_dst[DST_Z]   = 1'b1;
                IncPC            = 1'b1;
                alu_op           = ADD_OPC;
            end
            S_T1: begin
                // Asserted on every held cycle so MDR keeps sampling memory.
                bus_src[SRC_ZLO] = 1'b1;
                bus_dst[DST_PC]  = 1'b1;
                bus_dst[DST_MDR] = 1'b1;
                Read             = 1'b1;
            end
            S_T2: begin
                bus_src[SRC_MDR] = 1'b1;
                bus_dst[DST_IR]  = 1'b1;
            end
            S_T3: begin
                if (is_alu || is_imm) begin
                    gr_sel[GR_B]    = 1'b1;
                    bus_src[SRC_R]  = 1'b1;
                    bus_dst[DST_Y]  = 1'b1;
                end else if (is_muldiv) begin
                    gr_sel[GR_A]    = 1'b1;
                    bus_src[SRC_R]  = 1'b1;
                    bus_dst[DST_Y]  = 1'b1;
                end else if (is_negnot) begin
                    gr_sel[GR_B]    = 1'b1;
                    bus_src[SRC_R]  = 1'b1;
                    bus_dst[DST_Z]  = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    // Base register through BAout so that R0 reads as zero.
                    gr_sel[GR_B]    = 1'b1;
                    bus_src[SRC_BA] = 1'b1;
                    bus_dst[DST_Y]  = 1'b1;
                    alu_op          = ADD_OPC;
                end else if (is_mfhi) begin
                    bus_src[SRC_HI] = 1'b1;
                    gr_sel[GR_A]    = 1'b1;
                    bus_dst[DST_R]  = 1'b1;
                end else if (is_mflo) begin
                    bus_src[SRC_LO] = 1'b1;
                    gr_sel[GR_A]    = 1'b1;
                    bus_dst[DST_R]  = 1'b1;
                end else if (is_bad) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu || is_muldiv) begin
                    gr_sel[is_alu ? GR_C : GR_B] = 1'b1;
                    bus_src[SRC_R] = 1'b1;
                    bus_dst[DST_Z] = 1'b1;
                end else if (is_imm) begin
                    bus_src[SRC_C] = 1'b1;
                    bus_dst[DST_Z] = 1'b1;
                end else if (is_negnot) begin
                    bus_src[SRC_ZLO] = 1'b1;
                    gr_sel[GR_A]     = 1'b1;
                    bus_dst[DST_R]   = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    bus_src[SRC_C] = 1'b1;
                    bus_dst[DST_Z] = 1'b1;
                    alu_op         = ADD_OPC;
                end
            end
            S_T5: begin
                if (is_alu || is_imm || is_ldi) begin
                    bus_src[SRC_ZLO] = 1'b1;
                    gr_sel[GR_A]     = 1'b1;
                    bus_dst[DST_R]   = 1'b1;
                end else if (is_muldiv) begin
                    bus_src[SRC_ZLO] = 1'b1;
                    bus_dst[DST_LO]  = 1'b1;
                end else if (is_ld || is_st) begin
                    // Effective address moves from Z into MAR.
                    bus_src[SRC_ZLO] = 1'b1;
                    bus_dst[DST_MAR] = 1'b1;
                    alu_op           = ADD_OPC;
                end
            end
            S_T6: begin
                if (is_muldiv) begin
                    bus_src[SRC_ZHI] = 1'b1;
                    bus_dst[DST_HI]  = 1'b1;
                end else if (is_ld) begin
                    Read             = 1'b1;
                    bus_dst[DST_MDR] = 1'b1;
                end else if (is_st) begin
                    gr_sel[GR_A]     = 1'b1;
                    bus_src[SRC_R]   = 1'b1;
                    bus_dst[DST_MDR] = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    bus_src[SRC_MDR] = 1'b1;
                    gr_sel[GR_A]     = 1'b1;
                    bus_dst[DST_R]   = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: begin
                alu_op = '0;
                run    = 1'b0;
            end
        endcase
    end

endmodule
